// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared bus widths, enable levels and array sizing for the data-memory responder
package dmem_responder_pkg;
  localparam int RegBus = 32;
  localparam logic ChipEnable = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic WriteEnable = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam int DataMemNumLog2 = 10;
endpackage

// File: rtl/dmem_byte_bank.sv
// dmem_byte_bank: one byte lane of the data array, asynchronous read and single-port synchronous write
module dmem_byte_bank #(
  parameter int ADDR_W = 10,
  parameter int LANE = 0,
  parameter INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata
);
  logic [7:0] r_mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory with byte-lane writes and an optional wait-state sequencer
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = DataMemNumLog2,
  parameter int WAIT_STATES = 0,
  parameter INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [3:0]        sel_i,
  input  logic [RegBus-1:0] data_i,
  output logic [RegBus-1:0] data_o,
  output logic              stall_req_o
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;
  localparam bit ZERO_WAIT = WAIT_STATES == 0;
  state_t r_state;
  logic [3:0] r_cnt;
  logic r_we;
  logic [ADDR_W-1:0] r_idx;
  logic [3:0] r_sel;
  logic [RegBus-1:0] r_data;
  logic [ADDR_W-1:0] w_idx;
  logic [3:0] w_sel;
  logic [RegBus-1:0] w_wdata, w_rdata;
  logic w_commit, w_unused;
  assign w_unused = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
  // with wait states the array only ever sees the latched request, committed on the edge leaving DONE
  always_comb begin
    w_idx = ZERO_WAIT ? addr_i[ADDR_W+1:2] : r_idx;
    w_sel = ZERO_WAIT ? sel_i : r_sel;
    w_wdata = ZERO_WAIT ? data_i : r_data;
    w_commit = rst && (ZERO_WAIT ? (ce_i == ChipEnable && we_i == WriteEnable)
                                 : (r_state == S_DONE && r_we == WriteEnable));
    data_o = !rst ? ZeroWord
           : ZERO_WAIT ? ((ce_i == ChipEnable && we_i == WriteDisable) ? w_rdata : ZeroWord)
           : ((r_state == S_DONE && r_we == WriteDisable) ? w_rdata : ZeroWord);
    stall_req_o = rst && !ZERO_WAIT && (r_state == S_WAIT || (r_state == S_IDLE && ce_i == ChipEnable));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_we <= WriteDisable;
      r_idx <= '0;
      r_sel <= '0;
      r_data <= ZeroWord;
    end else begin
      case (r_state)
        S_IDLE:
          if (ce_i == ChipEnable && !ZERO_WAIT) begin
            r_we <= we_i;
            r_idx <= addr_i[ADDR_W+1:2];
            r_sel <= sel_i;
            r_data <= data_i;
            r_cnt <= 4'(WAIT_STATES - 1);
            r_state <= WAIT_STATES == 1 ? S_DONE : S_WAIT;
          end
        S_WAIT:
          if (ce_i == ChipDisable) r_state <= S_IDLE;
          else if (r_cnt == 4'd1) r_state <= S_DONE;
          else r_cnt <= r_cnt - 4'd1;
        default: r_state <= S_IDLE;
      endcase
    end
  for (genvar k = 0; k < 4; k++) begin : g_lane
    dmem_byte_bank #(.ADDR_W(ADDR_W), .LANE(k), .INIT_FILE(INIT_FILE)) u_bank (
      .clk    (clk),
      .i_we   (w_commit && w_sel[k]),
      .i_addr (w_idx),
      .i_wdata(w_wdata[8*k+:8]),
      .o_rdata(w_rdata[8*k+:8])
    );
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: four responder configurations checked against a word-array model with measured stall counts
module tb_dmem_responder;
  logic clk, rst;
  logic ce [4], we [4], stall [4];
  logic [31:0] addr [4], din [4], dout [4];
  logic [3:0] sel [4];
  int total = 0, bad = 0;
  int nw [4] = '{0, 3, 2, 0};
  int dep [4] = '{1024, 1024, 1024, 16};
  bit [31:0] mdl [4][1024];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(.ADDR_W(g == 3 ? 4 : 10), .WAIT_STATES(g == 1 ? 3 : g == 2 ? 2 : 0)) u_dut (
      .clk(clk), .rst(rst), .ce_i(ce[g]), .we_i(we[g]), .addr_i(addr[g]),
      .sel_i(sel[g]), .data_i(din[g]), .data_o(dout[g]), .stall_req_o(stall[g])
    );
  end

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    merge = o;
    for (int k = 0; k < 4; k++) if (s[k]) merge[8*k+:8] = n[8*k+:8];
  endfunction

  // one access: count stall cycles (scrambling the inputs meanwhile), then check the completion cycle
  task automatic acc(input int d, input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] v);
    int n, i;
    logic [31:0] e;
    i = int'(a[31:2]) % dep[d];
    e = w ? 32'h0 : mdl[d][i];
    @(negedge clk);
    ce[d] = 1; we[d] = w; addr[d] = a; sel[d] = s; din[d] = v;
    #1;
    n = 0;
    while (stall[d] === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
      addr[d] = $urandom; sel[d] = 4'($urandom); din[d] = $urandom;
      #1;
    end
    chk($sformatf("stalls%0d", d), 32'(n), 32'(nw[d]));
    chk($sformatf("done_stall%0d", d), 32'(stall[d]), 32'h0);
    chk($sformatf("data%0d@%h", d, a), dout[d], e);
    if (w) mdl[d][i] = merge(mdl[d][i], v, s);
    if (nw[d] != 0) ce[d] = 0;
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    ce[d] = 0;
    #1;
    chk($sformatf("idle_stall%0d", d), 32'(stall[d]), 32'h0);
    chk($sformatf("idle_data%0d", d), dout[d], 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    rst = 0;
    for (int d = 0; d < 4; d++) begin
      ce[d] = 1; we[d] = 0; addr[d] = 0; sel[d] = 4'hF; din[d] = 0;
    end
    #2;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_stall%0d", d), 32'(stall[d]), 32'h0);
      chk($sformatf("rst_data%0d", d), dout[d], 32'h0);
    end
    @(negedge clk);
    for (int d = 0; d < 4; d++) ce[d] = 0;
    rst = 1;
    // single-cycle memory
    acc(0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    acc(0, 0, 32'h10, 4'hF, 32'h0);
    chk("n0_read10", dout[0], 32'hDEADBEEF);
    acc(0, 1, 32'h20, 4'hF, 32'h11223344);
    acc(0, 1, 32'h21, 4'b0100, 32'hAAAAAAAA);
    acc(0, 0, 32'h20, 4'hF, 32'h0);
    chk("n0_lane2", dout[0], 32'h11AA3344);
    acc(0, 1, 32'h21, 4'b0011, 32'h55665566);
    acc(0, 0, 32'h20, 4'hF, 32'h0);
    chk("n0_lane10", dout[0], 32'h11AA5566);
    idle(0);
    // three wait states
    acc(1, 1, 32'h10, 4'hF, 32'hCAFEF00D);
    acc(1, 0, 32'h10, 4'hF, 32'h0);
    chk("n3_read10", dout[1], 32'hCAFEF00D);
    idle(1);
    acc(1, 1, 32'h30, 4'hF, 32'h0F0F0F0F);
    @(negedge clk);
    ce[1] = 1; we[1] = 1; addr[1] = 32'h30; sel[1] = 4'hF; din[1] = 32'h12345678;
    #1 chk("ab_idle", 32'(stall[1]), 32'h1);
    @(negedge clk);
    #1 chk("ab_wait1", 32'(stall[1]), 32'h1);
    @(negedge clk);
    ce[1] = 0;
    #1 chk("ab_wait2", 32'(stall[1]), 32'h1);
    @(negedge clk);
    #1 chk("ab_after_stall", 32'(stall[1]), 32'h0);
    chk("ab_after_data", dout[1], 32'h0);
    acc(1, 0, 32'h30, 4'hF, 32'h0);
    chk("ab_old", dout[1], 32'h0F0F0F0F);
    acc(1, 1, 32'h30, 4'h0, 32'hFFFFFFFF);
    acc(1, 0, 32'h30, 4'hF, 32'h0);
    chk("sel0_keep", dout[1], 32'h0F0F0F0F);
    // two wait states, asynchronous reset mid-access
    acc(2, 1, 32'h50, 4'hF, 32'h600DF00D);
    @(negedge clk);
    ce[2] = 1; we[2] = 1; addr[2] = 32'h50; sel[2] = 4'hF; din[2] = 32'hFFFFFFFF;
    #1 chk("rs_idle", 32'(stall[2]), 32'h1);
    @(negedge clk);
    #1 chk("rs_wait", 32'(stall[2]), 32'h1);
    rst = 0;
    #1 chk("rs_stall", 32'(stall[2]), 32'h0);
    chk("rs_data", dout[2], 32'h0);
    ce[2] = 0;
    #1 rst = 1;
    #1 chk("rs_release", 32'(stall[2]), 32'h0);
    idle(2);
    acc(2, 0, 32'h50, 4'hF, 32'h0);
    chk("rs_old", dout[2], 32'h600DF00D);
    // 16-word array aliasing
    acc(3, 1, 32'h40, 4'hF, 32'h0BADC0DE);
    acc(3, 0, 32'h00, 4'hF, 32'h0);
    chk("alias", dout[3], 32'h0BADC0DE);
    // randomized traffic against the word model
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < (d == 3 ? 16 : 8); i++) acc(d, 1, 32'(i) << 2, 4'hF, $urandom);
      for (int j = 0; j < 30; j++) begin
        a = d == 3 ? $urandom : (($urandom & 32'hFFFFF003) | (32'($urandom_range(7)) << 2));
        acc(d, 1'($urandom), a, 4'($urandom), $urandom);
      end
      idle(d);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
